// File: rtl/uart_cmd_decoder.sv
// Parses 5-byte SYNC/CMD/ADDR/DATA/SUM frames from the RX UART, runs register
// write/read cycles, and returns ACK/NAK (plus read data) over a ready/valid port.
module uart_cmd_decoder #(
    parameter int          TIMEOUT_CYCLES = 4160,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_write_o,
    output logic       reg_read_o,
    input  logic [7:0] reg_rdata_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       frame_error_o,
    output logic [7:0] drop_count_o
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;
    localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_SUM, S_EXEC, S_RDWAIT, S_RESP0, S_RESP1
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_cmd;
    logic [7:0]    r_addr;
    logic [7:0]    r_data;
    logic [7:0]    r_rdata;
    logic [7:0]    r_resp;
    logic          r_is_write;
    logic          r_send_rdata;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_drop;
    logic          r_frame_err;

    logic [7:0]    w_sum;
    logic          w_cmd_ok;
    logic          w_timer_hit;
    logic          w_in_frame;
    logic          w_busy;
    logic          w_good;
    logic          w_nak;
    logic          w_timeout;

    assign w_sum       = r_cmd + r_addr + r_data;
    assign w_cmd_ok    = (r_cmd == CMD_WRITE) || (r_cmd == CMD_READ);
    assign w_timer_hit = (r_timer == TIMER_LAST);
    assign w_in_frame  = (r_state == S_CMD) || (r_state == S_ADDR) ||
                         (r_state == S_DATA) || (r_state == S_SUM);
    assign w_busy      = (r_state == S_EXEC) || (r_state == S_RDWAIT) ||
                         (r_state == S_RESP0) || (r_state == S_RESP1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_good      = 1'b0;
        w_nak       = 1'b0;
        w_timeout   = 1'b0;
        reg_write_o = 1'b0;
        reg_read_o  = 1'b0;
        tx_valid_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid_i && (rx_data_i == SYNC_BYTE)) w_next = S_CMD;
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (rx_valid_i) begin
                    w_next = (r_state == S_CMD)  ? S_ADDR :
                             (r_state == S_ADDR) ? S_DATA : S_SUM;
                end else if (w_timer_hit) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_SUM: begin
                if (rx_valid_i) begin
                    if ((rx_data_i == w_sum) && w_cmd_ok) begin
                        w_next = S_EXEC;
                        w_good = 1'b1;
                    end else begin
                        w_next = S_RESP0;
                        w_nak  = 1'b1;
                    end
                end else if (w_timer_hit) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_EXEC: begin
                reg_write_o = r_is_write;
                reg_read_o  = !r_is_write;
                w_next      = r_is_write ? S_RESP0 : S_RDWAIT;
            end
            S_RDWAIT: w_next = S_RESP0;
            S_RESP0: begin
                tx_valid_o = 1'b1;
                if (tx_ready_i) w_next = r_send_rdata ? S_RESP1 : S_IDLE;
            end
            S_RESP1: begin
                tx_valid_o = 1'b1;
                if (tx_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Frame fields, response byte and read data capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd        <= 8'h00;
            r_addr       <= 8'h00;
            r_data       <= 8'h00;
            r_rdata      <= 8'h00;
            r_resp       <= 8'h00;
            r_is_write   <= 1'b0;
            r_send_rdata <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (rx_valid_i && (r_state == S_CMD))  r_cmd  <= rx_data_i;
            if (rx_valid_i && (r_state == S_ADDR)) r_addr <= rx_data_i;
            if (rx_valid_i && (r_state == S_DATA)) r_data <= rx_data_i;
            if (r_state == S_RDWAIT)               r_rdata <= reg_rdata_i;
            if (w_good) begin
                r_is_write   <= (r_cmd == CMD_WRITE);
                r_send_rdata <= (r_cmd == CMD_READ);
                r_resp       <= RESP_ACK;
            end else if (w_nak) begin
                r_send_rdata <= 1'b0;
                r_resp       <= RESP_NAK;
            end
            r_frame_err <= w_nak || w_timeout;
        end
    end

    // Timer restarts from zero on entry from IDLE and on every accepted byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
            r_drop  <= 8'h00;
        end else begin
            if (w_in_frame && !rx_valid_i) r_timer <= r_timer + TIMER_ONE;
            else                           r_timer <= '0;
            if (w_busy && rx_valid_i && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
        end
    end

    assign reg_addr_o    = r_addr;
    assign reg_wdata_o   = r_data;
    assign tx_data_o     = (r_state == S_RESP1) ? r_rdata : r_resp;
    assign frame_error_o = r_frame_err;
    assign drop_count_o  = r_drop;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: write/read frames, NAK cases, timeout,
// backpressure with busy drops, and asynchronous reset during a response.
module tb_uart_cmd_decoder;

    logic       clock;
    logic       reset_n;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_write_o;
    logic       reg_read_o;
    logic [7:0] reg_rdata_i;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       frame_error_o;
    logic [7:0] drop_count_o;

    uart_cmd_decoder dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rx_data_i     (rx_data_i),
        .rx_valid_i    (rx_valid_i),
        .reg_addr_o    (reg_addr_o),
        .reg_wdata_o   (reg_wdata_o),
        .reg_write_o   (reg_write_o),
        .reg_read_o    (reg_read_o),
        .reg_rdata_i   (reg_rdata_i),
        .tx_data_o     (tx_data_o),
        .tx_valid_o    (tx_valid_o),
        .tx_ready_i    (tx_ready_i),
        .frame_error_o (frame_error_o),
        .drop_count_o  (drop_count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register bus model: read data is presented only in the cycle after the strobe.
    logic [7:0] rd_val;
    logic       rd_pend = 1'b0;
    always @(posedge clock) rd_pend <= reg_read_o;
    assign reg_rdata_i = rd_pend ? rd_val : 8'h00;

    // Passive monitor, sampled on the falling edge.
    int         cyc = 0;
    int         last_rx_cyc = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         wr_cyc = 0;
    int         rd_cyc = 0;
    int         txv_rise_cyc = 0;
    int         ferr_cnt = 0;
    int         proto_err = 0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    logic       txv_prev = 1'b0;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] txq[$];

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (rx_valid_i) last_rx_cyc <= cyc;
        if (reg_write_o) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= reg_addr_o;
            wr_data <= reg_wdata_o;
            wr_cyc  <= cyc;
        end
        if (reg_read_o) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= reg_addr_o;
            rd_cyc  <= cyc;
        end
        if (frame_error_o) ferr_cnt <= ferr_cnt + 1;
        if (tx_valid_o && !txv_prev) txv_rise_cyc <= cyc;
        txv_prev <= tx_valid_o;
        if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
        if (reset_n && hold_prev && (!tx_valid_o || (tx_data_o != hold_data)))
            proto_err <= proto_err + 1;
        hold_prev <= reset_n && tx_valid_o && !tx_ready_i;
        hold_data <= tx_data_o;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clock);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] s);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(s);
    endtask

    int wr0, rd0, fe0, tx0;

    initial begin
        reset_n    = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b1;
        rd_val     = 8'h00;
        #3;
        check("reset_tx_valid", 32'(tx_valid_o), 32'h0);
        check("reset_write", 32'(reg_write_o), 32'h0);
        check("reset_read", 32'(reg_read_o), 32'h0);
        check("reset_ferr", 32'(frame_error_o), 32'h0);
        check("reset_drop", 32'(drop_count_o), 32'h0);
        check("reset_addr", 32'(reg_addr_o), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_cycles(2);

        // Garbage before a write frame.
        wr0 = wr_cnt; rd0 = rd_cnt; fe0 = ferr_cnt; tx0 = txq.size();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h57, 8'h03, 8'h5A, 8'hB4);
        wait_cycles(8);
        check("wr_pulses", 32'(wr_cnt - wr0), 32'd1);
        check("wr_no_read", 32'(rd_cnt - rd0), 32'd0);
        check("wr_addr", 32'(wr_addr), 32'h03);
        check("wr_data", 32'(wr_data), 32'h5A);
        check("wr_lat_strobe", 32'(wr_cyc - last_rx_cyc), 32'd1);
        check("wr_lat_txvalid", 32'(txv_rise_cyc - last_rx_cyc), 32'd2);
        check("wr_tx_count", 32'(txq.size() - tx0), 32'd1);
        check("wr_tx_ack", 32'(txq[tx0]), 32'h06);
        check("wr_no_ferr", 32'(ferr_cnt - fe0), 32'd0);
        check("garbage_no_drop", 32'(drop_count_o), 32'd0);
        check("wdata_holds", 32'(reg_wdata_o), 32'h5A);

        // Read frame.
        wr0 = wr_cnt; rd0 = rd_cnt; tx0 = txq.size();
        rd_val = 8'hC3;
        send_frame(8'h52, 8'h10, 8'h00, 8'h62);
        wait_cycles(10);
        check("rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        check("rd_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("rd_addr", 32'(rd_addr), 32'h10);
        check("rd_lat_strobe", 32'(rd_cyc - last_rx_cyc), 32'd1);
        check("rd_lat_txvalid", 32'(txv_rise_cyc - last_rx_cyc), 32'd3);
        check("rd_tx_count", 32'(txq.size() - tx0), 32'd2);
        check("rd_tx_ack", 32'(txq[tx0]), 32'h06);
        check("rd_tx_data", 32'(txq[tx0+1]), 32'hC3);

        // Bad checksum, then unknown command.
        wr0 = wr_cnt; rd0 = rd_cnt; fe0 = ferr_cnt; tx0 = txq.size();
        send_frame(8'h57, 8'h03, 8'h5A, 8'hB5);
        wait_cycles(8);
        check("badsum_no_strobe", 32'(wr_cnt - wr0 + rd_cnt - rd0), 32'd0);
        check("badsum_tx_count", 32'(txq.size() - tx0), 32'd1);
        check("badsum_nak", 32'(txq[tx0]), 32'h15);
        check("badsum_ferr", 32'(ferr_cnt - fe0), 32'd1);
        wr0 = wr_cnt; rd0 = rd_cnt; fe0 = ferr_cnt; tx0 = txq.size();
        send_frame(8'h41, 8'h00, 8'h00, 8'h41);
        wait_cycles(8);
        check("badcmd_no_strobe", 32'(wr_cnt - wr0 + rd_cnt - rd0), 32'd0);
        check("badcmd_tx_count", 32'(txq.size() - tx0), 32'd1);
        check("badcmd_nak", 32'(txq[tx0]), 32'h15);
        check("badcmd_ferr", 32'(ferr_cnt - fe0), 32'd1);

        // Inter-byte timeout, then a normal frame.
        fe0 = ferr_cnt; tx0 = txq.size(); wr0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h57);
        wait_cycles(4000);
        check("timeout_not_early", 32'(ferr_cnt - fe0), 32'd0);
        for (int i = 0; i < 400 && (ferr_cnt == fe0); i++) wait_cycles(1);
        wait_cycles(2);
        check("timeout_ferr", 32'(ferr_cnt - fe0), 32'd1);
        check("timeout_no_tx", 32'(txq.size() - tx0), 32'd0);
        check("timeout_no_write", 32'(wr_cnt - wr0), 32'd0);
        send_frame(8'h57, 8'h07, 8'h11, 8'h6F);
        wait_cycles(8);
        check("post_to_wr", 32'(wr_cnt - wr0), 32'd1);
        check("post_to_addr", 32'(wr_addr), 32'h07);
        check("post_to_data", 32'(wr_data), 32'h11);
        check("post_to_ack", 32'(txq[tx0]), 32'h06);

        // Backpressure with bytes dropped while busy.
        tx0 = txq.size();
        rd_val = 8'h3C;
        tx_ready_i = 1'b0;
        send_frame(8'h52, 8'h20, 8'h00, 8'h72);
        wait_cycles(10);
        send_byte(8'h11);
        wait_cycles(5);
        send_byte(8'hA5);
        wait_cycles(5);
        send_byte(8'h33);
        wait_cycles(1975);
        check("bp_tx_valid", 32'(tx_valid_o), 32'h1);
        check("bp_tx_data", 32'(tx_data_o), 32'h06);
        check("bp_drop_count", 32'(drop_count_o), 32'd3);
        check("bp_no_tx", 32'(txq.size() - tx0), 32'd0);
        tx_ready_i = 1'b1;
        wait_cycles(5);
        check("bp_tx_count", 32'(txq.size() - tx0), 32'd2);
        check("bp_tx_ack", 32'(txq[tx0]), 32'h06);
        check("bp_tx_rdata", 32'(txq[tx0+1]), 32'h3C);
        check("bp_protocol", 32'(proto_err), 32'd0);

        // Asynchronous reset while in RESP1.
        rd_val = 8'hC3;
        tx_ready_i = 1'b0;
        send_frame(8'h52, 8'h10, 8'h00, 8'h62);
        for (int i = 0; i < 20 && !tx_valid_o; i++) @(negedge clock);
        check("rst_resp0_seen", 32'(tx_valid_o), 32'h1);
        @(posedge clock);
        #1;
        tx_ready_i = 1'b1;
        @(posedge clock);
        #1;
        tx_ready_i = 1'b0;
        check("rst_resp1_valid", 32'(tx_valid_o), 32'h1);
        check("rst_resp1_data", 32'(tx_data_o), 32'hC3);
        check("rst_pre_drop", 32'(drop_count_o), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(tx_valid_o), 32'h0);
        check("rst_async_drop", 32'(drop_count_o), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        tx_ready_i = 1'b1;
        wait_cycles(2);
        wr0 = wr_cnt; tx0 = txq.size();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h57, 8'h03, 8'h5A, 8'hB4);
        wait_cycles(8);
        check("post_rst_wr", 32'(wr_cnt - wr0), 32'd1);
        check("post_rst_tx_count", 32'(txq.size() - tx0), 32'd1);
        check("post_rst_ack", 32'(txq[tx0]), 32'h06);
        check("post_rst_drop", 32'(drop_count_o), 32'd0);
        check("final_protocol", 32'(proto_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
